// File: rtl/mem_dma.sv
// XRAM-to-XRAM DMA engine: burst copy through a local buffer, or fill.
// Programmed through a 16-byte register window on the CPU XRAM bus.
module mem_dma #(
  parameter logic [15:0] ADDR_START  = 16'hfe40,
  parameter int          BLOCK_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        ack,
  output logic        in_addr_range,
  output logic [15:0] xram_addr,
  output logic [7:0]  xram_data_out,
  input  logic [7:0]  xram_data_in,
  output logic        xram_stb,
  output logic        xram_wr,
  input  logic        xram_ack,
  output logic [1:0]  state,
  output logic        irq,
  output logic [15:0] count
);

  localparam int IW = $clog2(BLOCK_BYTES);
  localparam logic [IW-1:0] IDX_LAST = IW'(BLOCK_BYTES - 1);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_READ  = 2'b01;
  localparam logic [1:0] S_WRITE = 2'b10;

  logic [1:0]    r_state;
  logic [15:0]   r_rd_addr;
  logic [15:0]   r_wr_addr;
  logic [15:0]   r_len;
  logic [7:0]    r_fill;
  logic          r_mode;
  logic          r_done;
  logic [IW-1:0] r_idx;
  logic [15:0]   r_count;
  logic [7:0]    r_buf [BLOCK_BYTES];

  logic [3:0]  w_off;
  logic        w_reg_wr;
  logic        w_ctrl_wr;
  logic        w_idle;
  logic        w_start;
  logic        w_abort;
  logic        w_clr;
  logic        w_xfer;
  logic [15:0] w_idx16;
  logic [15:0] w_rd_ptr;
  logic [15:0] w_wr_ptr;
  logic [15:0] w_cnt_nx;
  logic        w_rd_last;
  logic        w_wr_fin;
  logic [7:0]  w_rdata;
  logic [15:0] w_xaddr;

  assign w_off         = addr[3:0];
  assign in_addr_range = addr[15:4] == ADDR_START[15:4];
  assign ack           = stb && in_addr_range;
  assign w_reg_wr      = stb && wr && ack;
  assign w_ctrl_wr     = w_reg_wr && (w_off == 4'd0);
  assign w_idle        = r_state == S_IDLE;

  assign w_start = w_ctrl_wr && data_in[0] && !data_in[1] && w_idle;
  assign w_abort = w_ctrl_wr && data_in[1] && !w_idle;
  assign w_clr   = w_ctrl_wr && data_in[2];

  assign xram_stb = (r_state == S_READ) || (r_state == S_WRITE);
  assign xram_wr  = r_state == S_WRITE;
  assign w_xfer   = xram_stb && xram_ack;

  // in WRITE, count already advances with idx, so it alone locates the byte
  assign w_idx16  = 16'(r_idx);
  assign w_rd_ptr = r_rd_addr + r_count + w_idx16;
  assign w_wr_ptr = r_wr_addr + r_count;
  assign w_cnt_nx = r_count + 16'd1;

  assign w_rd_last = (r_idx == IDX_LAST) ||
                     ((r_count + w_idx16 + 16'd1) == r_len);
  assign w_wr_fin  = w_cnt_nx == r_len;

  always_comb begin
    w_xaddr = '0;
    if (r_state == S_READ)
      w_xaddr = w_rd_ptr;
    else if (r_state == S_WRITE)
      w_xaddr = w_wr_ptr;
  end

  assign xram_addr     = w_xaddr;
  assign xram_data_out = !xram_wr ? 8'h00 :
                         r_mode   ? r_fill : r_buf[r_idx];

  always_comb begin
    w_rdata = '0;
    if (in_addr_range) begin
      case (w_off)
        4'd0:    w_rdata = {3'b0, r_mode, 1'b0, r_done, 2'b0};
        4'd1:    w_rdata = {5'b0, r_done, r_state};
        4'd2:    w_rdata = r_rd_addr[7:0];
        4'd3:    w_rdata = r_rd_addr[15:8];
        4'd4:    w_rdata = r_wr_addr[7:0];
        4'd5:    w_rdata = r_wr_addr[15:8];
        4'd6:    w_rdata = r_len[7:0];
        4'd7:    w_rdata = r_len[15:8];
        4'd8:    w_rdata = r_fill;
        4'd10:   w_rdata = r_count[7:0];
        4'd11:   w_rdata = r_count[15:8];
        default: w_rdata = '0;
      endcase
    end
  end

  assign data_out = w_rdata;
  assign state    = r_state;
  assign irq      = r_done;
  assign count    = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_len     <= '0;
      r_fill    <= '0;
      r_mode    <= 1'b0;
      r_done    <= 1'b0;
      r_idx     <= '0;
      r_count   <= '0;
      for (int i = 0; i < BLOCK_BYTES; i++)
        r_buf[i] <= '0;
    end else begin
      if (w_reg_wr && w_idle) begin
        case (w_off)
          4'd0:    r_mode            <= data_in[4];
          4'd2:    r_rd_addr[7:0]    <= data_in;
          4'd3:    r_rd_addr[15:8]   <= data_in;
          4'd4:    r_wr_addr[7:0]    <= data_in;
          4'd5:    r_wr_addr[15:8]   <= data_in;
          4'd6:    r_len[7:0]        <= data_in;
          4'd7:    r_len[15:8]       <= data_in;
          4'd8:    r_fill            <= data_in;
          default: ;
        endcase
      end

      // any set below overrides this clear
      if (w_clr)
        r_done <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_count <= '0;
            r_idx   <= '0;
            if (r_len == 16'd0)
              r_done  <= 1'b1;
            else
              r_state <= data_in[4] ? S_WRITE : S_READ;
          end
        end
        S_READ: begin
          if (w_xfer) begin
            r_buf[r_idx] <= xram_data_in;
            if (w_rd_last) begin
              r_idx   <= '0;
              r_state <= S_WRITE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (w_xfer) begin
            r_count <= w_cnt_nx;
            if (w_wr_fin) begin
              r_idx   <= '0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else if (!r_mode && r_idx == IDX_LAST) begin
              r_idx   <= '0;
              r_state <= S_READ;
            end else if (!r_mode) begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_abort) begin
        r_idx   <= '0;
        r_done  <= 1'b1;
        r_state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// Randomised bench for mem_dma: XRAM model, transfer log and
// a burst-level reference of the expected bus transactions.
module tb_mem_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [7:0]  data_in = 8'h0;
  logic [7:0]  data_out;
  logic        ack;
  logic        in_addr_range;
  logic [15:0] xram_addr;
  logic [7:0]  xram_data_out;
  logic [7:0]  xram_data_in;
  logic        xram_stb;
  logic        xram_wr;
  logic        xram_ack = 1'b0;
  logic [1:0]  state;
  logic        irq;
  logic [15:0] count;

  mem_dma dut (
    .clk(clk), .rst(rst), .stb(stb), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .ack(ack),
    .in_addr_range(in_addr_range), .xram_addr(xram_addr),
    .xram_data_out(xram_data_out), .xram_data_in(xram_data_in),
    .xram_stb(xram_stb), .xram_wr(xram_wr), .xram_ack(xram_ack),
    .state(state), .irq(irq), .count(count)
  );

  logic [7:0]  mem    [65536];
  logic [7:0]  expmem [65536];
  logic [7:0]  scr    [65536];
  logic [24:0] lq[$];
  logic [24:0] eq[$];
  int vectors = 0;
  int miscompares = 0;
  bit hold = 1'b0;
  bit stall = 1'b0;

  always #5 clk = ~clk;

  assign xram_data_in = mem[xram_addr];

  always @(negedge clk)
    xram_ack <= hold ? 1'b0 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);

  always @(posedge clk) begin
    if (xram_stb && xram_ack) begin
      lq.push_back({xram_wr, xram_addr,
                    xram_wr ? xram_data_out : mem[xram_addr]});
      if (xram_wr)
        mem[xram_addr] <= xram_data_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cpu_wr(input logic [3:0] off, input logic [7:0] d);
    @(negedge clk);
    stb = 1'b1; wr = 1'b1;
    addr = 16'hfe40 + 16'(off); data_in = d;
    @(posedge clk);
    #1;
    stb = 1'b0; wr = 1'b0; addr = 16'h0;
  endtask

  task automatic cpu_rd(input logic [3:0] off, output logic [7:0] d);
    @(negedge clk);
    stb = 1'b1; wr = 1'b0; addr = 16'hfe40 + 16'(off);
    #1;
    d = data_out;
    stb = 1'b0; addr = 16'h0;
  endtask

  task automatic prog(input logic [15:0] rd, input logic [15:0] wa,
                      input logic [15:0] len, input logic [7:0] fill);
    cpu_wr(4'd2, rd[7:0]);  cpu_wr(4'd3, rd[15:8]);
    cpu_wr(4'd4, wa[7:0]);  cpu_wr(4'd5, wa[15:8]);
    cpu_wr(4'd6, len[7:0]); cpu_wr(4'd7, len[15:8]);
    cpu_wr(4'd8, fill);
  endtask

  // expected transaction list: burst-wise read-all-then-write-all
  task automatic build(input bit mode, input logic [15:0] rd,
                       input logic [15:0] wa, input int len,
                       input logic [7:0] fill);
    logic [7:0]  tmp [32];
    logic [15:0] a;
    int base, bl;
    eq.delete();
    scr = expmem;
    if (mode) begin
      for (int i = 0; i < len; i++)
        eq.push_back({1'b1, 16'(wa + 16'(i)), fill});
    end else begin
      base = 0;
      while (base < len) begin
        bl = (len - base > 32) ? 32 : len - base;
        for (int i = 0; i < bl; i++) begin
          a = 16'(rd + 16'(base + i));
          tmp[i] = scr[a];
          eq.push_back({1'b0, a, scr[a]});
        end
        for (int i = 0; i < bl; i++) begin
          a = 16'(wa + 16'(base + i));
          scr[a] = tmp[i];
          eq.push_back({1'b1, a, tmp[i]});
        end
        base += bl;
      end
    end
  endtask

  task automatic commit(input int nwr);
    int k;
    k = 0;
    foreach (eq[i])
      if (eq[i][24] && k < nwr) begin
        expmem[eq[i][23:8]] = eq[i][7:0];
        k++;
      end
  endtask

  function automatic int nwrites();
    int n;
    n = 0;
    foreach (lq[i])
      if (lq[i][24]) n++;
    return n;
  endfunction

  task automatic cmp_log(input bit prefix);
    int n;
    if (prefix)
      chk("log_prefix_len", 32'(lq.size() <= eq.size()), 32'd1);
    else
      chk("log_len", 32'(lq.size()), 32'(eq.size()));
    n = (lq.size() < eq.size()) ? lq.size() : eq.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("xfer%0d", i), 32'(lq[i]), 32'(eq[i]));
  endtask

  task automatic mem_cmp(input string tag);
    int d;
    d = 0;
    for (int i = 0; i < 65536; i++)
      if (mem[i] !== expmem[i]) d++;
    chk(tag, 32'(d), 32'd0);
  endtask

  task automatic wait_irq(input int budget, output int cyc);
    cyc = 1;
    while (!irq && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("irq_timeout", 32'(irq), 32'd1);
  endtask

  task automatic run_op(input bit mode, input logic [15:0] rd,
                        input logic [15:0] wa, input logic [15:0] len,
                        input logic [7:0] fill, output int cyc);
    prog(rd, wa, len, fill);
    build(mode, rd, wa, int'(len), fill);
    lq.delete();
    cpu_wr(4'd0, {3'b0, mode, 4'b0101});
    wait_irq(40 * int'(len) + 100, cyc);
    cmp_log(1'b0);
    commit(int'(len));
  endtask

  initial begin
    logic [7:0]  d;
    logic [15:0] ra, wa, ln;
    int cyc, wc, t, nlog;
    bit md;

    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      expmem[i] = mem[i];
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stb", 32'(xram_stb), 32'd0);
    chk("rst_wr", 32'(xram_wr), 32'd0);
    chk("rst_xaddr", 32'(xram_addr), 32'd0);
    chk("rst_xdata", 32'(xram_data_out), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    rst = 1'b0;
    cpu_rd(4'd1, d);
    chk("rst_status", 32'(d), 32'd0);
    cpu_rd(4'd6, d);
    chk("rst_len", 32'(d), 32'd0);

    // 40-byte copy, ack always high
    run_op(1'b0, 16'h0100, 16'h0200, 16'd40, 8'h00, cyc);
    chk("cp40_cycles", 32'(cyc), 32'd81);
    chk("cp40_count", 32'(count), 32'd40);
    cpu_rd(4'd10, d);
    chk("cp40_cnt_lo", 32'(d), 32'd40);
    cpu_rd(4'd11, d);
    chk("cp40_cnt_hi", 32'(d), 32'd0);
    mem_cmp("cp40_mem");

    // fill
    run_op(1'b1, 16'h0000, 16'h0300, 16'd5, 8'hA5, cyc);
    chk("fill_cycles", 32'(cyc), 32'd6);
    cpu_rd(4'd0, d);
    chk("fill_ctrl_rd", 32'(d), 32'h14);
    mem_cmp("fill_mem");

    // zero length
    cpu_wr(4'd0, 8'h04);
    chk("clr_done", 32'(irq), 32'd0);
    cpu_wr(4'd6, 8'h00);
    cpu_wr(4'd7, 8'h00);
    lq.delete();
    cpu_wr(4'd0, 8'h01);
    cpu_rd(4'd1, d);
    chk("len0_status", 32'(d), 32'h04);
    repeat (5) @(posedge clk);
    #1;
    chk("len0_noxfer", 32'(lq.size()), 32'd0);

    // abort after 3 write acks of a 10-byte copy
    prog(16'h0500, 16'h0600, 16'd10, 8'h00);
    build(1'b0, 16'h0500, 16'h0600, 10, 8'h00);
    lq.delete();
    cpu_wr(4'd0, 8'h05);
    wc = 0;
    t = 0;
    while (wc < 3 && t < 200) begin
      @(posedge clk);
      #1;
      wc = nwrites();
      t++;
    end
    hold = 1'b1;
    xram_ack = 1'b0;
    chk("ab_wc", 32'(wc), 32'd3);
    cpu_wr(4'd0, 8'h02);
    chk("ab_state", 32'(state), 32'd0);
    chk("ab_count", 32'(count), 32'd3);
    chk("ab_done", 32'(irq), 32'd1);
    hold = 1'b0;
    cmp_log(1'b1);
    commit(3);
    cpu_wr(4'd6, 8'h07);
    cpu_rd(4'd6, d);
    chk("ab_len_wr", 32'(d), 32'h07);
    cpu_wr(4'd2, 8'h34);
    cpu_rd(4'd2, d);
    chk("ab_rd_wr", 32'(d), 32'h34);
    mem_cmp("ab_mem");

    // busy lockout
    prog(16'h0700, 16'h0800, 16'd16, 8'h00);
    build(1'b0, 16'h0700, 16'h0800, 16, 8'h00);
    lq.delete();
    cpu_wr(4'd0, 8'h05);
    cpu_wr(4'd6, 8'h55);
    cpu_rd(4'd6, d);
    chk("lock_len", 32'(d), 32'd16);
    wait_irq(200, cyc);
    cmp_log(1'b0);
    commit(16);

    // address wrap
    run_op(1'b0, 16'hFFFE, 16'h4000, 16'd4, 8'h00, cyc);
    chk("wrap_a0", 32'(lq[0][23:8]), 32'hFFFE);
    chk("wrap_a1", 32'(lq[1][23:8]), 32'hFFFF);
    chk("wrap_a2", 32'(lq[2][23:8]), 32'h0000);
    chk("wrap_a3", 32'(lq[3][23:8]), 32'h0001);
    mem_cmp("wrap_mem");

    // random ops with ack stalls
    stall = 1'b1;
    for (int k = 0; k < 6; k++) begin
      md = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      wa = 16'($urandom);
      ln = 16'($urandom_range(1, 80));
      run_op(md, ra, wa, ln, 8'($urandom), cyc);
      mem_cmp($sformatf("rnd%0d_mem", k));
    end

    // reset in the middle of a copy
    ra = 16'($urandom);
    wa = 16'($urandom);
    prog(ra, wa, 16'd60, 8'h00);
    build(1'b0, ra, wa, 60, 8'h00);
    lq.delete();
    cpu_wr(4'd0, 8'h05);
    repeat ($urandom_range(5, 60)) @(posedge clk);
    #1;
    hold = 1'b1;
    xram_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mr_state", 32'(state), 32'd0);
    chk("mr_stb", 32'(xram_stb), 32'd0);
    chk("mr_wr", 32'(xram_wr), 32'd0);
    chk("mr_xaddr", 32'(xram_addr), 32'd0);
    chk("mr_xdata", 32'(xram_data_out), 32'd0);
    chk("mr_irq", 32'(irq), 32'd0);
    chk("mr_count", 32'(count), 32'd0);
    hold = 1'b0;
    cmp_log(1'b1);
    commit(nwrites());
    nlog = lq.size();
    repeat (10) @(posedge clk);
    #1;
    chk("mr_noxfer", 32'(lq.size()), 32'(nlog));
    chk("mr_irq_late", 32'(irq), 32'd0);
    cpu_rd(4'd6, d);
    chk("mr_len", 32'(d), 32'd0);
    mem_cmp("mr_mem");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
